writer_scoreboard: RTL and testbench

//  Producer-side companion to the forwarding logic: records every register writer issued from ID

---
 rtl/writer_scoreboard_pkg.sv | 25 ++
 rtl/writer_scoreboard_src_hazard_check.sv | 36 +++
 rtl/writer_scoreboard.sv | 112 +++++++++++
 tb/tb_writer_scoreboard.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/writer_scoreboard_pkg.sv
// Shared register-file constants, the in-flight writer slot record and the
// readiness rule used by the writer scoreboard and its hazard checkers.
package writer_scoreboard_pkg;

    localparam int REG_W    = 5;
    localparam int NUM_REGS = 32;
    localparam int SLOT_W   = REG_W + 2;

    localparam logic [REG_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic             valid;
        logic             is_load;
        logic [REG_W-1:0] rd;
    } slot_t;

    localparam slot_t SLOT_EMPTY = '0;

    // A writer becomes forwardable once it has aged to its result latency.
    function automatic logic slot_ready(input logic is_load, input int age,
                                        input int alu_lat, input int load_lat);
        return age >= (is_load ? load_lat : alu_lat);
    endfunction

endpackage

// File: rtl/writer_scoreboard_src_hazard_check.sv
// Hazard check for one source operand: finds the youngest in-flight writer of
// the source register and reports whether its value cannot be forwarded yet.
module src_hazard_check
    import writer_scoreboard_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int ALU_LAT  = 1,
    parameter int LOAD_LAT = 2
) (
    input  logic [DEPTH*SLOT_W-1:0] slots,
    input  logic                    uses,
    input  logic [REG_W-1:0]        src,
    output logic                    not_ready
);

    slot_t cur;
    logic  found;

    // Slot 0 is the youngest; the first match shadows any older writer.
    always_comb begin
        not_ready = 1'b0;
        found     = 1'b0;
        cur       = SLOT_EMPTY;
        for (int k = 0; k < DEPTH; k++) begin
            cur = slots[k*SLOT_W +: SLOT_W];
            if (!found && cur.valid && (cur.rd == src)) begin
                found     = 1'b1;
                not_ready = !slot_ready(cur.is_load, k + 1, ALU_LAT, LOAD_LAT);
            end
        end
        if (!uses || (src == REG_ZERO)) begin
            not_ready = 1'b0;
        end
    end

endmodule

// File: rtl/writer_scoreboard.sv
// Writer scoreboard: shifts every issued register writer down a DEPTH-slot
// history, raises stall when a source of the ID instruction is not forwardable.
module writer_scoreboard
    import writer_scoreboard_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int ALU_LAT  = 1,
    parameter int LOAD_LAT = 2,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                issue_valid,
    input  logic                issue_regwrite,
    input  logic                issue_is_load,
    input  logic [REG_W-1:0]    issue_rd,
    input  logic [REG_W-1:0]    id_rs,
    input  logic [REG_W-1:0]    id_rt,
    input  logic                id_uses_rs,
    input  logic                id_uses_rt,
    input  logic                flush_ex,
    output logic                stall,
    output logic [NUM_REGS-1:0] busy_mask,
    output logic [CNT_W-1:0]    stall_cycles
);

    generate
        if ((ALU_LAT < 1) || (ALU_LAT > LOAD_LAT) || (LOAD_LAT > DEPTH)) begin : g_bad_params
            $error("writer_scoreboard: need 1 <= ALU_LAT <= LOAD_LAT <= DEPTH");
        end
    endgenerate

    slot_t                   slot_q [DEPTH];
    slot_t                   slot_d [DEPTH];
    logic [DEPTH*SLOT_W-1:0] slots_flat;
    logic [NUM_REGS-1:0]     busy_d;
    logic                    rs_not_ready;
    logic                    rt_not_ready;

    always_comb begin
        slots_flat = '0;
        for (int k = 0; k < DEPTH; k++) begin
            slots_flat[k*SLOT_W +: SLOT_W] = slot_q[k];
        end
    end

    src_hazard_check #(
        .DEPTH    (DEPTH),
        .ALU_LAT  (ALU_LAT),
        .LOAD_LAT (LOAD_LAT)
    ) u_rs_check (
        .slots     (slots_flat),
        .uses      (id_uses_rs),
        .src       (id_rs),
        .not_ready (rs_not_ready)
    );

    src_hazard_check #(
        .DEPTH    (DEPTH),
        .ALU_LAT  (ALU_LAT),
        .LOAD_LAT (LOAD_LAT)
    ) u_rt_check (
        .slots     (slots_flat),
        .uses      (id_uses_rt),
        .src       (id_rt),
        .not_ready (rt_not_ready)
    );

    // A flushed ID instruction is discarded, so it never needs to wait.
    assign stall = (rs_not_ready | rt_not_ready) & ~flush_ex;

    // Stalled or flushed cycles push a bubble; a flush also kills the writer issued last cycle.
    always_comb begin
        slot_d[0]         = SLOT_EMPTY;
        slot_d[0].valid   = issue_valid & issue_regwrite & (issue_rd != REG_ZERO)
                            & ~stall & ~flush_ex;
        slot_d[0].is_load = issue_is_load;
        slot_d[0].rd      = issue_rd;
        for (int k = 1; k < DEPTH; k++) begin
            slot_d[k] = ((k == 1) && flush_ex) ? SLOT_EMPTY : slot_q[k-1];
        end
    end

    always_comb begin
        busy_d = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (slot_d[k].valid) begin
                busy_d[slot_d[k].rd] = 1'b1;
            end
        end
        busy_d[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                slot_q[k] <= SLOT_EMPTY;
            end
            busy_mask    <= '0;
            stall_cycles <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                slot_q[k] <= slot_d[k];
            end
            busy_mask <= busy_d;
            if (stall && (stall_cycles != {CNT_W{1'b1}})) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_writer_scoreboard.sv
// Bench for writer_scoreboard: a timestamped in-flight-writer model checked every
// cycle, directed hazard scenarios, and a deep-latency instance for counter saturation.
module tb_writer_scoreboard;

  localparam int DEPTH    = 4;
  localparam int ALU_LAT  = 1;
  localparam int LOAD_LAT = 2;
  localparam int CNT_MAX  = 65535;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        issue_valid, issue_regwrite, issue_is_load, flush_ex;
  logic [4:0]  issue_rd, id_rs, id_rt;
  logic        id_uses_rs, id_uses_rt;
  logic        stall;
  logic [31:0] busy_mask;
  logic [15:0] stall_cycles;

  logic        s_issue_valid, s_issue_regwrite, s_issue_is_load, s_flush_ex;
  logic [4:0]  s_issue_rd, s_id_rs, s_id_rt;
  logic        s_id_uses_rs, s_id_uses_rt;
  logic        s_stall;
  logic [31:0] s_busy_mask;
  logic [15:0] s_stall_cycles;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  writer_scoreboard dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .issue_valid    (issue_valid),
    .issue_regwrite (issue_regwrite),
    .issue_is_load  (issue_is_load),
    .issue_rd       (issue_rd),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_uses_rs     (id_uses_rs),
    .id_uses_rt     (id_uses_rt),
    .flush_ex       (flush_ex),
    .stall          (stall),
    .busy_mask      (busy_mask),
    .stall_cycles   (stall_cycles)
  );

  writer_scoreboard #(.DEPTH(64), .ALU_LAT(1), .LOAD_LAT(64), .CNT_W(16)) dut_sat (
    .clk            (clk),
    .rst_n          (rst_n),
    .issue_valid    (s_issue_valid),
    .issue_regwrite (s_issue_regwrite),
    .issue_is_load  (s_issue_is_load),
    .issue_rd       (s_issue_rd),
    .id_rs          (s_id_rs),
    .id_rt          (s_id_rt),
    .id_uses_rs     (s_id_uses_rs),
    .id_uses_rt     (s_id_uses_rt),
    .flush_ex       (s_flush_ex),
    .stall          (s_stall),
    .busy_mask      (s_busy_mask),
    .stall_cycles   (s_stall_cycles)
  );

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Model: list of live writers stamped with the edge count at issue.
  typedef struct {
    logic [4:0] rd;
    logic       is_load;
    int         t;
  } wr_t;

  wr_t live_q[$];
  int  now   = 0;
  int  m_cnt = 0;

  function automatic logic src_blocked(input logic [4:0] src, input logic use_it);
    int   best = -1;
    logic ld = 1'b0;
    if (!use_it || src == 5'd0) return 1'b0;
    foreach (live_q[i]) begin
      if (live_q[i].rd == src && live_q[i].t > best) begin
        best = live_q[i].t;
        ld   = live_q[i].is_load;
      end
    end
    if (best < 0) return 1'b0;
    return (now - best) < (ld ? LOAD_LAT : ALU_LAT);
  endfunction

  function automatic logic model_stall();
    if (flush_ex) return 1'b0;
    return src_blocked(id_rs, id_uses_rs) | src_blocked(id_rt, id_uses_rt);
  endfunction

  function automatic logic [31:0] model_busy();
    logic [31:0] m = '0;
    foreach (live_q[i]) m[live_q[i].rd] = 1'b1;
    return m;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_q.delete();
      now   = 0;
      m_cnt = 0;
    end else begin
      logic st;
      st = model_stall();
      if (st && m_cnt < CNT_MAX) m_cnt++;
      if (flush_ex) begin
        for (int i = live_q.size() - 1; i >= 0; i--)
          if (now - live_q[i].t == 1) live_q.delete(i);
      end
      if (issue_valid && issue_regwrite && issue_rd != 5'd0 && !st && !flush_ex)
        live_q.push_back('{issue_rd, issue_is_load, now});
      now++;
      for (int i = live_q.size() - 1; i >= 0; i--)
        if (now - live_q[i].t > DEPTH) live_q.delete(i);
    end
  end

  always @(negedge clk) begin
    check("stall", 64'(stall), 64'(model_stall()));
    check("busy_mask", 64'(busy_mask), 64'(model_busy()));
    check("stall_cycles", 64'(stall_cycles), 64'(m_cnt));
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 1'b0; issue_regwrite = 1'b0; issue_is_load = 1'b0; issue_rd = 5'd0;
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0; flush_ex = 1'b0;
  endtask

  task automatic issue(input logic ld, input logic [4:0] rd);
    issue_valid = 1'b1; issue_regwrite = 1'b1; issue_is_load = ld; issue_rd = rd;
  endtask

  task automatic id_reads(input logic [4:0] rs, input logic [4:0] rt, input logic urs, input logic urt);
    id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
  endtask

  task automatic drain(input int n);
    idle();
    repeat (n) next_cycle();
  endtask

  initial begin
    bit hit;
    idle();
    s_issue_valid = 1'b0; s_issue_regwrite = 1'b0; s_issue_is_load = 1'b0; s_issue_rd = 5'd0;
    s_id_rs = 5'd0; s_id_rt = 5'd0; s_id_uses_rs = 1'b0; s_id_uses_rt = 1'b0; s_flush_ex = 1'b0;

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_stall", 64'(stall), 64'd0);
    check("reset_busy", 64'(busy_mask), 64'd0);
    check("reset_cnt", 64'(stall_cycles), 64'd0);
    next_cycle();

    // Load-use on rs: one stall cycle, the consumer is held and a bubble enters.
    issue(1'b1, 5'd5);
    @(negedge clk); check("lu_issue_stall", 64'(stall), 64'd0);
    next_cycle();
    idle(); issue(1'b0, 5'd9); id_reads(5'd5, 5'd0, 1'b1, 1'b0);
    @(negedge clk); check("lu_stall", 64'(stall), 64'd1);
    check("lu_busy", 64'(busy_mask), 64'h20);
    next_cycle();
    @(negedge clk); check("lu_release", 64'(stall), 64'd0);
    check("lu_bubble_busy", 64'(busy_mask), 64'h20);
    next_cycle();
    idle();
    @(negedge clk); check("lu_consumer_busy", 64'(busy_mask), 64'h220);
    check("lu_cnt", 64'(stall_cycles), 64'd1);
    drain(DEPTH + 1);

    // ALU-use on rt never stalls; r7 stays busy for DEPTH cycles.
    issue(1'b0, 5'd7);
    next_cycle();
    idle(); id_reads(5'd0, 5'd7, 1'b0, 1'b1);
    for (int i = 0; i <= DEPTH; i++) begin
      @(negedge clk);
      check("alu_stall", 64'(stall), 64'd0);
      check("alu_busy7", 64'(busy_mask[7]), 64'(i < DEPTH));
      next_cycle();
      idle();
    end

    // Writes to r0 are never tracked.
    issue(1'b1, 5'd0);
    next_cycle();
    idle(); id_reads(5'd0, 5'd0, 1'b1, 1'b1);
    @(negedge clk); check("r0_stall", 64'(stall), 64'd0);
    check("r0_busy", 64'(busy_mask), 64'd0);
    drain(2);

    // Load whose consumer ignores the matching operand.
    issue(1'b1, 5'd8);
    next_cycle();
    idle(); id_reads(5'd0, 5'd8, 1'b0, 1'b0);
    @(negedge clk); check("unused_rt_stall", 64'(stall), 64'd0);
    drain(DEPTH + 1);

    // Flush squashes the load and suppresses its stall.
    issue(1'b1, 5'd3);
    next_cycle();
    idle(); issue(1'b0, 5'd3); id_reads(5'd3, 5'd0, 1'b1, 1'b0); flush_ex = 1'b1;
    @(negedge clk); check("flush_stall", 64'(stall), 64'd0);
    check("flush_busy_before", 64'(busy_mask), 64'h8);
    next_cycle();
    idle();
    @(negedge clk); check("flush_busy_after", 64'(busy_mask), 64'd0);
    drain(2);

    // Load r4 then ALU r4: youngest writer is ready.
    issue(1'b1, 5'd4);
    next_cycle();
    idle(); issue(1'b0, 5'd4);
    next_cycle();
    idle(); id_reads(5'd4, 5'd0, 1'b1, 1'b0);
    @(negedge clk); check("shadow_alu_stall", 64'(stall), 64'd0);
    drain(DEPTH + 1);

    // ALU r6 then load r6: youngest writer is the unready load.
    issue(1'b0, 5'd6);
    next_cycle();
    idle(); issue(1'b1, 5'd6);
    next_cycle();
    idle(); id_reads(5'd0, 5'd6, 1'b0, 1'b1);
    @(negedge clk); check("shadow_load_stall", 64'(stall), 64'd1);
    drain(DEPTH + 1);

    // Deep-latency instance: repeated load-use drives the counter to saturation.
    s_issue_valid = 1'b1; s_issue_regwrite = 1'b1; s_issue_is_load = 1'b1; s_issue_rd = 5'd5;
    s_id_rs = 5'd5; s_id_uses_rs = 1'b1;
    repeat (64) @(posedge clk);
    @(negedge clk);
    check("sat_first_period_cnt", 64'(s_stall_cycles), 64'd63);
    check("sat_first_period_stall", 64'(s_stall), 64'd0);
    repeat (67000 - 64) @(posedge clk);
    @(negedge clk);
    check("sat_cnt", 64'(s_stall_cycles), 64'hffff);
    next_cycle();

    // Asynchronous reset while both instances stall.
    issue(1'b1, 5'd5); id_reads(5'd5, 5'd0, 1'b1, 1'b0);
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      if (stall && s_stall) hit = 1'b1;
    end
    check("mid_stall_reached", 64'(hit), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_stall", 64'(stall), 64'd0);
    check("async_rst_busy", 64'(busy_mask), 64'd0);
    check("async_rst_cnt", 64'(stall_cycles), 64'd0);
    check("async_rst_sat_stall", 64'(s_stall), 64'd0);
    check("async_rst_sat_busy", 64'(s_busy_mask), 64'd0);
    check("async_rst_sat_cnt", 64'(s_stall_cycles), 64'd0);
    idle();
    s_issue_valid = 1'b0; s_id_uses_rs = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    drain(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
